// File: rtl/sa_operand_feeder_if.sv
// Operand feeder bus: upstream vector handshake plus per-lane handshake toward the array edge.
interface sa_operand_feeder_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4
) ();
  logic [LANES*DATA_W-1:0] vec_in;
  logic                    vec_valid;
  logic                    vec_ready;
  logic [LANES*DATA_W-1:0] lane_data;
  logic [LANES-1:0]        lane_valid;
  logic [LANES-1:0]        lane_ready;

  modport master (
    output vec_in, vec_valid, lane_ready,
    input  vec_ready, lane_data, lane_valid
  );

  modport slave (
    input  vec_in, vec_valid, lane_ready,
    output vec_ready, lane_data, lane_valid
  );
endinterface

// File: rtl/sa_operand_feeder.sv
// Systolic-array operand feeder: splits each input vector into per-lane FIFOs and releases
// lane i element k only after lane i-1 has delivered element k, producing the diagonal skew.
module sa_operand_feeder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned FIFO_D = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  sa_operand_feeder_if.slave io_feed
);

  localparam int unsigned PTR_W = $clog2(FIFO_D);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]  r_len_q;
  logic [CNT_W-1:0]  r_in_cnt;
  logic [CNT_W-1:0]  r_sent   [LANES];
  logic [OCC_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_rd_ptr [LANES];
  logic [DATA_W-1:0] r_mem    [LANES][FIFO_D];
  logic              r_done;

  logic                    w_done_nxt;
  logic                    w_start_job;
  logic                    w_vec_ready;
  logic                    w_xfer;
  logic                    w_last_in;
  logic [LANES-1:0]        w_full;
  logic [LANES-1:0]        w_empty;
  logic [LANES-1:0]        w_lane_valid;
  logic [LANES-1:0]        w_pop;
  logic [LANES*DATA_W-1:0] w_lane_data;

  // All lanes are written together, so one write pointer serves every FIFO.
  always_comb begin
    w_full      = '0;
    w_empty     = '0;
    w_lane_data = '0;
    for (int i = 0; i < LANES; i++) begin
      w_empty[i] = (r_wr_ptr == r_rd_ptr[i]);
      w_full[i]  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[i][PTR_W-1:0]) &&
                   (r_wr_ptr[PTR_W] != r_rd_ptr[i][PTR_W]);
      w_lane_data[i*DATA_W +: DATA_W] = r_mem[i][r_rd_ptr[i][PTR_W-1:0]];
    end
  end

  // Lane i may only run behind lane i-1, never level with or ahead of it.
  always_comb begin
    w_lane_valid    = '0;
    w_lane_valid[0] = !w_empty[0];
    for (int i = 1; i < LANES; i++) begin
      w_lane_valid[i] = !w_empty[i] && (r_sent[i] < r_sent[i-1]);
    end
    w_pop = w_lane_valid & io_feed.lane_ready;
  end

  assign w_vec_ready = (r_state == ST_STREAM) && (r_in_cnt < r_len_q) && !(|w_full);
  assign w_xfer      = io_feed.vec_valid && w_vec_ready;
  assign w_last_in   = ((r_in_cnt + CNT_W'(1)) == r_len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_start_job = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            w_start_job = 1'b1;
            w_state_nxt = ST_STREAM;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (w_xfer && w_last_in) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_sent[LANES-1] == r_len_q) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Job counters, FIFO pointers and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_q  <= '0;
      r_in_cnt <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_rd_ptr[i] <= '0;
        r_sent[i]   <= '0;
        for (int j = 0; j < FIFO_D; j++) begin
          r_mem[i][j] <= '0;
        end
      end
    end else if (w_start_job) begin
      r_len_q  <= i_len;
      r_in_cnt <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_rd_ptr[i] <= '0;
        r_sent[i]   <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_in_cnt <= r_in_cnt + CNT_W'(1);
        r_wr_ptr <= r_wr_ptr + OCC_W'(1);
        for (int i = 0; i < LANES; i++) begin
          r_mem[i][r_wr_ptr[PTR_W-1:0]] <= io_feed.vec_in[i*DATA_W +: DATA_W];
        end
      end
      for (int i = 0; i < LANES; i++) begin
        if (w_pop[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + OCC_W'(1);
          r_sent[i]   <= r_sent[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_busy             = (r_state != ST_IDLE);
  assign o_done             = r_done;
  assign io_feed.vec_ready  = w_vec_ready;
  assign io_feed.lane_valid = w_lane_valid;
  assign io_feed.lane_data  = w_lane_data;

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Bench for sa_operand_feeder: queue-based lane model checked every cycle, plus directed literal checks.
module tb_sa_operand_feeder;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned FIFO_D = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned VW     = LANES * DATA_W;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b1;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_len   = '0;
  logic             o_busy;
  logic             o_done;

  sa_operand_feeder_if #(.DATA_W(DATA_W), .LANES(LANES)) feed ();

  sa_operand_feeder #(
    .DATA_W(DATA_W), .LANES(LANES), .FIFO_D(FIFO_D), .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_len   (i_len),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .io_feed (feed.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per-lane queues of pending elements and per-lane delivered counts.
  logic [DATA_W-1:0] m_q [LANES][$];
  int   m_sent [LANES];
  int   m_in     = 0;
  int   m_len    = 0;
  int   m_jobs   = 0;
  logic m_active = 1'b0;
  logic m_done   = 1'b0;

  function automatic logic exp_vready();
    logic full;
    full = 1'b0;
    for (int i = 0; i < LANES; i++) if (m_q[i].size() >= int'(FIFO_D)) full = 1'b1;
    return m_active && (m_in < m_len) && !full;
  endfunction

  function automatic logic [LANES-1:0] exp_lvalid();
    logic [LANES-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m_q[i].size() > 0) begin
        if (i == 0) v[i] = 1'b1;
        else if (m_sent[i] < m_sent[i-1]) v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  logic             mv_vr;
  logic [LANES-1:0] mv_lv;
  logic             mv_fin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        m_q[i].delete();
        m_sent[i] = 0;
      end
      m_in = 0; m_len = 0; m_active = 1'b0; m_done = 1'b0;
    end else begin
      mv_vr  = exp_vready();
      mv_lv  = exp_lvalid();
      mv_fin = m_active && (m_in == m_len) && (m_sent[LANES-1] == m_len);
      m_done = 1'b0;
      if (!m_active) begin
        if (i_start) begin
          if (i_len != '0) begin
            m_active = 1'b1; m_len = int'(i_len); m_in = 0;
            for (int i = 0; i < LANES; i++) m_sent[i] = 0;
          end else begin
            m_done = 1'b1; m_jobs++;
          end
        end
      end else if (mv_fin) begin
        m_active = 1'b0; m_done = 1'b1; m_jobs++;
      end else begin
        if (mv_vr && feed.vec_valid) begin
          for (int i = 0; i < LANES; i++) m_q[i].push_back(feed.vec_in[i*DATA_W +: DATA_W]);
          m_in++;
        end
        for (int i = 0; i < LANES; i++) begin
          if (mv_lv[i] && feed.lane_ready[i]) begin
            void'(m_q[i].pop_front());
            m_sent[i]++;
          end
        end
      end
    end
  end

  // Observed DUT deliveries per lane.
  int                obs_sent [LANES];
  logic [DATA_W-1:0] obs_q    [LANES][$];
  int                obs_t    [LANES][$];
  int   cyc_n     = 0;
  int   done_cnt  = 0;
  logic busy_seen = 1'b0;
  logic lv_seen   = 1'b0;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    logic [LANES-1:0] lv;
    logic [VW-1:0]    mask;
    logic [VW-1:0]    expd;
    lv   = exp_lvalid();
    mask = '0;
    expd = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lv[i] || !rst_n) begin
        mask[i*DATA_W +: DATA_W] = '1;
        if (rst_n) expd[i*DATA_W +: DATA_W] = m_q[i][0];
      end
    end
    chk("busy",       64'(o_busy),             64'(m_active));
    chk("done",       64'(o_done),             64'(m_done));
    chk("vec_ready",  64'(feed.vec_ready),     64'(exp_vready()));
    chk("lane_valid", 64'(feed.lane_valid),    64'(lv));
    chk("lane_data",  64'(feed.lane_data & mask), 64'(expd));
    if (o_done) done_cnt++;
    if (o_busy) busy_seen = 1'b1;
    if (|feed.lane_valid) lv_seen = 1'b1;
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) obs_sent[i] = 0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (i > 0) begin
          if (feed.lane_valid[i]) chk("lane_order", 64'(obs_sent[i] < obs_sent[i-1]), 64'(1));
        end
        if (feed.lane_valid[i] && feed.lane_ready[i]) begin
          obs_sent[i]++;
          obs_q[i].push_back(feed.lane_data[i*DATA_W +: DATA_W]);
          obs_t[i].push_back(cyc_n);
        end
      end
    end
  end

  logic [VW-1:0] src_q [$];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [LANES-1:0] ready_pat(input int rmode, input int cyc);
    logic [LANES-1:0] r;
    r = '1;
    if (rmode == 1 && cyc >= 2 && cyc < 12) r[2] = 1'b0;
    if (rmode == 2) r = LANES'($urandom);
    return r;
  endfunction

  // vmode 0: always valid, 1: random. rmode 0: all ready, 1: lane 2 stalled 10 cycles, 2: random.
  task automatic run_job(input int len, input int vmode, input int rmode, input int restart_at,
                         input int abort_sent, input int budget);
    int   idx;
    int   cyc;
    int   jobs0;
    int   d0;
    logic adv;
    idx = 0; cyc = 0;
    for (int i = 0; i < LANES; i++) begin
      obs_q[i].delete(); obs_t[i].delete(); obs_sent[i] = 0;
    end
    jobs0 = m_jobs;
    d0    = done_cnt;
    i_start = 1'b1; i_len = CNT_W'(len);
    step();
    i_start = 1'b0;
    while (m_jobs == jobs0 && cyc < budget) begin
      if (abort_sent >= 0 && m_sent[LANES-1] >= abort_sent) break;
      feed.vec_valid  = (idx < len) && (vmode == 0 || $urandom_range(0, 1) == 1);
      feed.vec_in     = (idx < len) ? src_q[idx] : '0;
      feed.lane_ready = ready_pat(rmode, cyc);
      if (cyc == restart_at) begin
        i_start = 1'b1; i_len = CNT_W'(5);
      end else begin
        i_start = 1'b0;
      end
      adv = feed.vec_valid && exp_vready();
      if (rmode == 1 && cyc == 11) begin
        chk("stall_vec_ready",   64'(feed.vec_ready),   64'(0));
        chk("stall_lane2_depth", 64'(m_q[2].size()),   64'(FIFO_D));
      end
      step();
      if (adv) idx++;
      cyc++;
    end
    i_start = 1'b0;
    feed.vec_valid  = 1'b0;
    feed.lane_ready = '1;
    chk("job_in_budget", 64'(cyc < budget), 64'(1));
    if (abort_sent < 0) begin
      step();
      chk("done_once", 64'(done_cnt - d0), 64'(1));
    end
  endtask

  task automatic check_streams(input string tag, input int len);
    for (int i = 0; i < LANES; i++) begin
      chk({tag, "_count"}, 64'(obs_q[i].size()), 64'(len));
      for (int k = 0; k < len && k < obs_q[i].size(); k++) begin
        chk({tag, "_data"}, 64'(obs_q[i][k]), 64'(src_q[k][i*DATA_W +: DATA_W]));
      end
    end
  endtask

  task automatic fill_random(input int n);
    src_q.delete();
    for (int k = 0; k < n; k++) src_q.push_back(VW'($urandom));
  endtask

  initial begin
    int d0;
    logic [VW-1:0] v;
    feed.vec_valid  = 1'b0;
    feed.vec_in     = '0;
    feed.lane_ready = '1;
    #1 rst_n = 1'b0;
    step(); step();
    chk("rst_busy",       64'(o_busy),          64'(0));
    chk("rst_done",       64'(o_done),          64'(0));
    chk("rst_vec_ready",  64'(feed.vec_ready),  64'(0));
    chk("rst_lane_valid", 64'(feed.lane_valid), 64'(0));
    chk("rst_lane_data",  64'(feed.lane_data),  64'(0));
    rst_n = 1'b1;
    step();

    // Three vectors 0x01.., 0x11.., 0x21.. with full ready: one-cycle skew per lane.
    src_q.delete();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = DATA_W'(8'h01 + 8'h10 * k + i);
      src_q.push_back(v);
    end
    run_job(3, 0, 0, -1, -1, 100);
    for (int i = 0; i < LANES; i++) begin
      chk("basic_count", 64'(obs_q[i].size()), 64'(3));
      for (int k = 0; k < 3 && k < obs_q[i].size(); k++) begin
        chk("basic_data", 64'(obs_q[i][k]), 64'(8'h01 + 8'h10 * k + i));
        chk("basic_skew", 64'(obs_t[i][k] - obs_t[0][k]), 64'(i));
      end
    end

    // Lane 2 held off for 10 cycles: backpressure fills its FIFO and blocks the input.
    fill_random(6);
    run_job(6, 0, 1, -1, -1, 200);
    check_streams("stall", 6);

    // Zero-length job.
    busy_seen = 1'b0; lv_seen = 1'b0; d0 = done_cnt;
    i_start = 1'b1; i_len = '0;
    step();
    i_start = 1'b0;
    chk("len0_done", 64'(o_done), 64'(1));
    step();
    chk("len0_done_drop", 64'(o_done), 64'(0));
    step();
    chk("len0_busy_never",  64'(busy_seen),       64'(0));
    chk("len0_valid_never", 64'(lv_seen),         64'(0));
    chk("len0_done_count",  64'(done_cnt - d0),   64'(1));

    // Start re-pulsed mid-job with len 5 is ignored.
    fill_random(5);
    run_job(3, 0, 0, 1, -1, 100);
    check_streams("restart", 3);
    step();
    chk("restart_idle", 64'(o_busy), 64'(0));

    // Reset mid-job, then a fresh single-vector job.
    fill_random(4);
    run_job(4, 0, 0, -1, 2, 100);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",       64'(o_busy),          64'(0));
    chk("midrst_done",       64'(o_done),          64'(0));
    chk("midrst_vec_ready",  64'(feed.vec_ready),  64'(0));
    chk("midrst_lane_valid", 64'(feed.lane_valid), 64'(0));
    chk("midrst_lane_data",  64'(feed.lane_data),  64'(0));
    step(); step();
    rst_n = 1'b1;
    step();
    fill_random(1);
    run_job(1, 0, 0, -1, -1, 100);
    check_streams("post_rst", 1);

    // Long job with random valid and random ready.
    fill_random(200);
    run_job(200, 1, 2, -1, -1, 6000);
    check_streams("random", 200);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_operand_feeder.md
SA_OPERAND_FEEDER -- requirements
Module: sa_operand_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand element width in bits.
REQ-002 SHALL have parameter LANES, default 4, number of array edge lanes (rows/columns) driven.
REQ-003 SHALL have parameter FIFO_D, default 4, per-lane FIFO depth in entries (power of two, >=2).
REQ-004 SHALL have parameter CNT_W, default 8, width of the vector-length counter.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle job start request; sampled only in IDLE.
REQ-008 len  input  CNT_W  number of vectors in the job; sampled with start.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse at job completion.
REQ-011 vec_in  input  LANES*DATA_W  operand vector; element i at bits [i*DATA_W +: DATA_W].
REQ-012 vec_valid / vec_ready  input / output  1 each  upstream vector handshake.
REQ-013 lane_data  output  LANES*DATA_W  per-lane operand to the array edge, same packing as vec_in.
REQ-014 lane_valid / lane_ready  output / input  LANES each  per-lane handshake to the edge PEs.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM, FLUSH.
REQ-016 IDLE: start=1 with len!=0 -> latch len, clear all counters -> STREAM; start=1 with len=0 -> done=1 next cycle, remain IDLE.
REQ-017 start SHALL be ignored in STREAM and FLUSH.
REQ-018 vec_ready SHALL equal (state==STREAM) && (in_cnt < len_q) && no lane FIFO full; a transfer occurs when vec_valid && vec_ready.
REQ-019 On a transfer, element i SHALL be written to lane i FIFO and in_cnt incremented; in_cnt reaching len_q -> FLUSH.
REQ-020 Each lane SHALL keep a registered sent count sent[i], incremented on lane_valid[i] && lane_ready[i].
REQ-021 lane_valid[0] SHALL equal lane 0 FIFO non-empty; lane_valid[i], i>0, SHALL equal FIFO i non-empty && sent[i] < sent[i-1].
REQ-022 Consequence: lane i element k is never presented before the cycle after lane i-1 element k is accepted; with all ready high the skew is exactly 1 cycle per lane.
REQ-023 lane_data[i] SHALL be the FIFO i head; data and valid SHALL be held stable while valid && !ready.
REQ-024 FIFO write and read in the same cycle SHALL both occur; occupancy unchanged; pointers wrap modulo FIFO_D.
REQ-025 A write SHALL never occur into a full FIFO (guaranteed by REQ-018); a read SHALL never occur from an empty FIFO.
REQ-026 FLUSH: when sent[LANES-1] == len_q, done SHALL pulse 1 cycle and state SHALL return to IDLE the same edge.
REQ-027 Latency: vector accepted at edge t -> lane 0 valid from cycle t+1 (empty FIFO), lane i valid from t+1+i under full ready.
REQ-028 Data SHALL pass unmodified; no arithmetic on operands.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, busy=0, done=0, vec_ready=0, lane_valid=0, lane_data=0, all FIFO pointers, in_cnt, sent[] and len_q to 0.
REQ-030 Reset mid-job SHALL discard all buffered data; first cycle after release behaves as fresh IDLE.

Verification
REQ-031 len=3, vectors {0x01,0x02,0x03,0x04},{0x11..0x14},{0x21..0x24}, all ready=1 -> lane i outputs 0x01+i,0x11+i,0x21+i starting i cycles after lane 0; done pulses once after lane 3's third accept.
REQ-032 len=6, lane_ready[2]=0 for 10 cycles -> lanes 3 stalls behind lane 2, FIFOs fill to 4, vec_ready=0 until release; no data lost, order preserved.
REQ-033 start with len=0 -> done=1 next cycle, busy never asserts, lane_valid stays 0.
REQ-034 start pulsed again during STREAM with len=5 -> ignored; job completes with original len.
REQ-035 rst_n asserted after 2 of 4 vectors sent -> all outputs 0 same cycle; new job len=1 after release completes correctly.
REQ-036 Random vec_valid and lane_ready, len=200 -> per-lane scoreboard matches, REQ-021 ordering assertion never fires, exactly one done.
